// File: rtl/mod_exp_ctrl_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation controller
// and its bit-serial MonMult engine.
package mod_exp_ctrl_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_EXP_BITS = 64;

    localparam logic [DEF_WIDTH-1:0] ONE = 64'd1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        TO_MONT_X   = 3'd1,
        TO_MONT_ONE = 3'd2,
        SQUARE      = 3'd3,
        MULT        = 3'd4,
        FROM_MONT   = 3'd5,
        DONE        = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_RUN  = 2'd1,
        MM_WAIT = 2'd2
    } mm_state_t;

    // One radix-2 Montgomery step: (s + a_bit*b + q*m) / 2, with q chosen so the sum is even.
    // Two guard bits keep s < 4m without overflow.
    function automatic logic [DEF_WIDTH+1:0] mm_step(
        input logic [DEF_WIDTH+1:0] s,
        input logic [DEF_WIDTH-1:0] b,
        input logic [DEF_WIDTH-1:0] m,
        input logic                 a_bit
    );
        logic [DEF_WIDTH+1:0] t;
        if (a_bit) begin
            t = s + {2'b00, b};
        end else begin
            t = s;
        end
        if (t[0]) begin
            t = t + {2'b00, m};
        end else begin
            t = t;
        end
        return t >> 1;
    endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Request/result bundle for mod_exp_ctrl: operands and start from the host,
// result, busy and done back from the engine.
interface mod_exp_ctrl_if
    import mod_exp_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int EXP_BITS = DEF_EXP_BITS
) ();

    logic                start;
    logic [WIDTH-1:0]    X;
    logic [EXP_BITS-1:0] E;
    logic [WIDTH-1:0]    M;
    logic [WIDTH-1:0]    R2;
    logic [WIDTH-1:0]    Y;
    logic                busy;
    logic                done;

    modport master (
        output start, X, E, M, R2,
        input  Y, busy, done
    );

    modport slave (
        input  start, X, E, M, R2,
        output Y, busy, done
    );

endinterface

// File: rtl/mod_exp_ctrl_monmult.sv
// Bit-serial Montgomery multiplier: P = A*B*2^-64 mod M, one A bit per cycle.
// is_ready pulses once per GO-high interval; a new operation starts only after GO drops.
module mod_exp_ctrl_monmult
    import mod_exp_ctrl_pkg::*;
(
    input  logic                 pclk,
    input  logic                 nreset,
    input  logic                 GO,
    input  logic [DEF_WIDTH-1:0] A,
    input  logic [DEF_WIDTH-1:0] B,
    input  logic [DEF_WIDTH-1:0] M,
    output logic [DEF_WIDTH-1:0] P,
    output logic                 is_ready
);

    mm_state_t            st_r;
    logic [DEF_WIDTH-1:0] a_r;
    logic [DEF_WIDTH-1:0] b_r;
    logic [DEF_WIDTH-1:0] m_r;
    logic [DEF_WIDTH+1:0] s_r;
    logic [6:0]           cnt_r;
    logic [DEF_WIDTH-1:0] p_r;
    logic                 rdy_r;

    logic [DEF_WIDTH+1:0] s_next_s;
    logic [DEF_WIDTH-1:0] p_next_s;

    // Next accumulator value and the final conditional subtraction.
    always_comb begin
        s_next_s = mm_step(s_r, b_r, m_r, a_r[0]);
        if (s_next_s >= {2'b00, m_r}) begin
            p_next_s = 64'(s_next_s - {2'b00, m_r});
        end else begin
            p_next_s = 64'(s_next_s);
        end
    end

    // Operation sequencer and datapath registers.
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            st_r  <= MM_IDLE;
            a_r   <= 64'd0;
            b_r   <= 64'd0;
            m_r   <= 64'd0;
            s_r   <= 66'd0;
            cnt_r <= 7'd0;
            p_r   <= 64'd0;
            rdy_r <= 1'b0;
        end else begin
            case (st_r)
                MM_IDLE: begin
                    rdy_r <= 1'b0;
                    if (GO) begin
                        a_r   <= A;
                        b_r   <= B;
                        m_r   <= M;
                        s_r   <= 66'd0;
                        cnt_r <= 7'd0;
                        st_r  <= MM_RUN;
                    end
                end
                MM_RUN: begin
                    s_r   <= s_next_s;
                    a_r   <= a_r >> 1;
                    cnt_r <= cnt_r + 7'd1;
                    if (cnt_r == 7'(DEF_WIDTH - 1)) begin
                        p_r   <= p_next_s;
                        rdy_r <= 1'b1;
                        st_r  <= MM_WAIT;
                    end
                end
                MM_WAIT: begin
                    rdy_r <= 1'b0;
                    if (!GO) begin
                        st_r <= MM_IDLE;
                    end
                end
                default: begin
                    rdy_r <= 1'b0;
                    st_r  <= MM_IDLE;
                end
            endcase
        end
    end

    assign P        = p_r;
    assign is_ready = rdy_r;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation in the Montgomery domain,
// sequencing a single shared MonMult engine through a GO/is_ready handshake.
module mod_exp_ctrl
    import mod_exp_ctrl_pkg::*;
#(
    parameter int EXP_BITS = DEF_EXP_BITS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic          pclk,
    input  logic          reset,
    mod_exp_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(EXP_BITS);

    state_t              state_r;
    logic [WIDTH-1:0]    x_r;
    logic [EXP_BITS-1:0] e_r;
    logic [WIDTH-1:0]    m_r;
    logic [WIDTH-1:0]    r2_r;
    logic [WIDTH-1:0]    xb_r;
    logic [WIDTH-1:0]    ab_r;
    logic [WIDTH-1:0]    y_r;
    logic [6:0]          idx_r;
    logic                busy_r;
    logic                done_r;

    logic [WIDTH-1:0]    mm_A;
    logic [WIDTH-1:0]    mm_B;
    logic                mm_GO;
    logic [WIDTH-1:0]    mm_P;
    logic                mm_is_ready;

    logic [WIDTH-1:0]    op_a_s;
    logic [WIDTH-1:0]    op_b_s;
    logic                e_bit_s;
    logic                last_bit_s;

    assign e_bit_s    = e_r[idx_r[IDX_W-1:0]];
    assign last_bit_s = (idx_r == 7'd0);

    // Operand selection for the MonMult issued in the current state.
    always_comb begin
        op_a_s = ab_r;
        op_b_s = ab_r;
        case (state_r)
            TO_MONT_X: begin
                op_a_s = x_r;
                op_b_s = r2_r;
            end
            TO_MONT_ONE: begin
                op_a_s = ONE;
                op_b_s = r2_r;
            end
            SQUARE: begin
                op_a_s = ab_r;
                op_b_s = ab_r;
            end
            MULT: begin
                op_a_s = ab_r;
                op_b_s = xb_r;
            end
            FROM_MONT: begin
                op_a_s = ab_r;
                op_b_s = ONE;
            end
            default: begin
                op_a_s = ab_r;
                op_b_s = ab_r;
            end
        endcase
    end

    // Control FSM: every operation state raises GO with registered operands, waits for
    // is_ready, captures the product and drops GO for one cycle before the next operation.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_r <= IDLE;
            x_r     <= '0;
            e_r     <= '0;
            m_r     <= '0;
            r2_r    <= '0;
            xb_r    <= '0;
            ab_r    <= '0;
            y_r     <= '0;
            idx_r   <= 7'(EXP_BITS - 1);
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mm_A    <= '0;
            mm_B    <= '0;
            mm_GO   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        x_r     <= bus.X;
                        e_r     <= bus.E;
                        m_r     <= bus.M;
                        r2_r    <= bus.R2;
                        idx_r   <= 7'(EXP_BITS - 1);
                        busy_r  <= 1'b1;
                        state_r <= TO_MONT_X;
                    end
                end
                TO_MONT_X, TO_MONT_ONE, SQUARE, MULT, FROM_MONT: begin
                    if (!mm_GO) begin
                        mm_A  <= op_a_s;
                        mm_B  <= op_b_s;
                        mm_GO <= 1'b1;
                    end else if (mm_is_ready) begin
                        mm_GO <= 1'b0;
                        case (state_r)
                            TO_MONT_X: begin
                                xb_r    <= mm_P;
                                state_r <= TO_MONT_ONE;
                            end
                            TO_MONT_ONE: begin
                                ab_r    <= mm_P;
                                state_r <= SQUARE;
                            end
                            SQUARE: begin
                                ab_r <= mm_P;
                                if (e_bit_s) begin
                                    state_r <= MULT;
                                end else if (last_bit_s) begin
                                    state_r <= FROM_MONT;
                                end else begin
                                    idx_r <= idx_r - 7'd1;
                                end
                            end
                            MULT: begin
                                ab_r <= mm_P;
                                if (last_bit_s) begin
                                    state_r <= FROM_MONT;
                                end else begin
                                    idx_r   <= idx_r - 7'd1;
                                    state_r <= SQUARE;
                                end
                            end
                            FROM_MONT: begin
                                y_r     <= mm_P;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= DONE;
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    mm_GO   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    mod_exp_ctrl_monmult u_monmult (
        .pclk     (pclk),
        .nreset   (~reset),
        .GO       (mm_GO),
        .A        (mm_A),
        .B        (mm_B),
        .M        (m_r),
        .P        (mm_P),
        .is_ready (mm_is_ready)
    );

    assign bus.Y    = y_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: directed cases plus random operands checked
// against a plain-arithmetic modular exponentiation model.
module tb_mod_exp_ctrl;
    import mod_exp_ctrl_pkg::*;

    logic pclk = 1'b0;
    logic reset;

    always #5 pclk = ~pclk;

    mod_exp_ctrl_if bus ();

    mod_exp_ctrl dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   go_rises  = 0;
    int   gap_bad   = 0;
    int   run_rises = 0;
    int   low_len   = 0;
    logic go_prev   = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    // Count GO-high intervals and flag any GO-low gap inside a run that is not one cycle.
    always @(negedge pclk) begin
        if (dut.mm_GO && !go_prev) begin
            go_rises++;
            if (run_rises > 0 && low_len != 1) gap_bad++;
            run_rises++;
        end
        low_len = dut.mm_GO ? 0 : low_len + 1;
        if (!bus.busy) run_rises = 0;
        go_prev = dut.mm_GO;
    end

    // Right-to-left binary exponentiation with wide products.
    function automatic logic [63:0] ref_modexp(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m);
        logic [127:0] r;
        logic [127:0] b;
        r = 128'd1 % {64'd0, m};
        b = {64'd0, x} % {64'd0, m};
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % {64'd0, m};
            b = (b * b) % {64'd0, m};
        end
        return r[63:0];
    endfunction

    function automatic logic [63:0] ref_r2(input logic [63:0] m);
        logic [127:0] r;
        r = 128'd1 % {64'd0, m};
        for (int i = 0; i < 128; i++) r = (r << 1) % {64'd0, m};
        return r[63:0];
    endfunction

    task automatic launch(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m,
                          input logic [63:0] r2, output int go_base, output int gap_base);
        @(posedge pclk);
        #1;
        bus.X = x; bus.E = e; bus.M = m; bus.R2 = r2;
        bus.start = 1'b1;
        go_base  = go_rises;
        gap_base = gap_bad;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
        check_val("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp_y, input int exp_go,
                             input int go_base, input int gap_base);
        int cyc;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20000) begin
            @(posedge pclk);
            #1;
            cyc++;
        end
        check_val({tag, "_done"}, 64'(bus.done), 64'd1);
        if (bus.done === 1'b1) begin
            check_val({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
            check_val({tag, "_y"}, bus.Y, exp_y);
            check_val({tag, "_go_count"}, 64'(go_rises - go_base), 64'(exp_go));
            check_val({tag, "_go_gaps"}, 64'(gap_bad - gap_base), 64'd0);
            @(posedge pclk);
            #1;
            check_val({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
            check_val({tag, "_y_held"}, bus.Y, exp_y);
        end
    endtask

    task automatic run_case(input string tag, input logic [63:0] x, input logic [63:0] e,
                            input logic [63:0] m, input logic [63:0] r2, input logic [63:0] exp_y);
        int gb;
        int pb;
        launch(x, e, m, r2, gb, pb);
        finish_op(tag, exp_y, 3 + 64 + $countones(e), gb, pb);
    endtask

    initial begin
        int gb;
        int pb;
        int cyc;
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] e;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.X = 64'd0; bus.E = 64'd0; bus.M = 64'd0; bus.R2 = 64'd0;
        @(posedge pclk);
        #1;
        bus.start = 1'b1;
        @(posedge pclk);
        #1;
        reset = 1'b0;
        bus.start = 1'b0;
        check_val("rst_y", bus.Y, 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_go", 64'(dut.mm_GO), 64'd0);
        @(posedge pclk);
        #1;
        check_val("start_with_reset_ignored", 64'(bus.busy), 64'd0);

        run_case("x3e5m7", 64'd3, 64'd5, 64'd7, 64'd4, 64'd5);
        run_case("x2e12m13", 64'd2, 64'd12, 64'd13, 64'd9, 64'd1);
        run_case("e_zero", 64'd5, 64'd0, 64'd7, 64'd4, 64'd1);
        run_case("e_ones", 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd4,
                 ref_modexp(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7));
        run_case("m_one", 64'd0, 64'h0000_0000_8000_0013, 64'd1, 64'd0, 64'd0);

        // start pulsed while squaring must be ignored
        launch(64'd3, 64'd5, 64'd7, 64'd4, gb, pb);
        repeat (300) @(posedge pclk);
        #1;
        check_val("in_square", 64'(dut.state_r), 64'(SQUARE));
        bus.X = 64'd4; bus.E = 64'd3; bus.M = 64'd11; bus.R2 = 64'd3;
        bus.start = 1'b1;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
        finish_op("start_while_busy", 64'd5, 69, gb, pb);

        for (int k = 0; k < 4; k++) begin
            m = {$urandom, $urandom};
            m[63] = 1'b0;
            m[0] = 1'b1;
            x = {$urandom, $urandom} % m;
            e = {$urandom, $urandom};
            run_case($sformatf("rand%0d", k), x, e, m, ref_r2(m), ref_modexp(x, e, m));
        end

        // reset during MULT aborts, then a normal run
        launch(64'd3, 64'd5, 64'd7, 64'd4, gb, pb);
        cyc = 0;
        while (dut.state_r != MULT && cyc < 10000) begin
            @(posedge pclk);
            #1;
            cyc++;
        end
        check_val("reached_mult", 64'(dut.state_r), 64'(MULT));
        reset = 1'b1;
        @(posedge pclk);
        #1;
        reset = 1'b0;
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        check_val("abort_done", 64'(bus.done), 64'd0);
        check_val("abort_go", 64'(dut.mm_GO), 64'd0);
        run_case("after_abort", 64'd3, 64'd5, 64'd7, 64'd4, 64'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
